// File: rtl/sar_search.sv
// sar_search: binary-search controller driving an external GT/EQ/LS comparator to find its A operand.
module sar_search #(
    parameter int WIDTH = 4,
    parameter int ITW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gt,
    input  logic             eq,
    input  logic             ls,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [ITW-1:0]   iters
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE, ERR} state_t;
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [ITW-1:0] LIMIT = ITW'(WIDTH + 1);
    state_t state, state_n;
    logic [WIDTH-1:0] lo, hi, lo_n, hi_n, guess_n, result_n, lo_upd, hi_upd;
    logic [ITW-1:0] iters_n, iters_inc;
    logic [WIDTH:0] sum;
    logic bad;
    assign busy = state == SEARCH;
    assign done = state == DONE;
    assign error = state == ERR;
    always_comb begin
        state_n = state;
        lo_n = lo;
        hi_n = hi;
        guess_n = guess;
        result_n = result;
        iters_n = iters;
        iters_inc = (&iters) ? iters : iters + 1'b1;
        bad = !(gt ^ eq ^ ls) || (gt && eq && ls);
        lo_upd = gt ? guess + 1'b1 : lo;
        hi_upd = ls ? guess - 1'b1 : hi;
        sum = {1'b0, lo_upd} + {1'b0, hi_upd};
        unique case (state)
            IDLE: if (start) begin
                lo_n = '0;
                hi_n = MAX;
                guess_n = MAX >> 1;
                iters_n = '0;
                state_n = SEARCH;
            end
            SEARCH: begin
                iters_n = iters_inc;
                if (bad) state_n = ERR;
                else if (eq) begin
                    result_n = guess;
                    state_n = DONE;
                end
                else if ((gt && guess == MAX) || (ls && guess == '0)) state_n = ERR;
                else if (lo_upd > hi_upd || iters_inc == LIMIT) state_n = ERR;
                else begin
                    lo_n = lo_upd;
                    hi_n = hi_upd;
                    guess_n = sum[WIDTH:1];
                end
            end
            DONE: state_n = IDLE;
            ERR: state_n = IDLE;
        endcase
        // result is cleared as ERR is entered so it already reads 0 during the error pulse
        if (state == SEARCH && state_n == ERR) result_n = '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lo <= '0;
            hi <= MAX;
            guess <= '0;
            result <= '0;
            iters <= '0;
        end else begin
            state <= state_n;
            lo <= lo_n;
            hi <= hi_n;
            guess <= guess_n;
            result <= result_n;
            iters <= iters_n;
        end
    end
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: table-driven and randomized checks of sar_search against a binary-search model.
module tb_sar_search;
    logic clk, rst, start, gt, eq, ls, busy, done, error;
    logic [3:0] guess, result, target;
    logic [2:0] iters;
    int mode;
    int passed = 0;
    int total = 0;

    sar_search #(.WIDTH(4), .ITW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .gt(gt), .eq(eq), .ls(ls),
        .guess(guess), .busy(busy), .done(done), .error(error),
        .result(result), .iters(iters)
    );

    // mode 0: honest comparator, 1: gt and eq both stuck high, 2: gt stuck high alone
    assign gt = mode != 0 || target > guess;
    assign eq = mode == 1 || (mode == 0 && target == guess);
    assign ls = mode == 0 && target < guess;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk)
        if (!rst) chk("exclusive", int'((done && error) || (busy && (done || error))), 0);

    function automatic void model(input int t, input int m, output int seq[8], output int n,
                                  output bit ok, output int res, output int it);
        int lo, hi, g;
        bit fg, fe, fl;
        lo = 0; hi = 15; n = 0; ok = 0; res = 0; it = 0;
        for (int i = 1; i <= 5; i++) begin
            g = (lo + hi) / 2;
            seq[n] = g; n++; it = i;
            fg = m != 0 || t > g;
            fe = m == 1 || (m == 0 && t == g);
            fl = m == 0 && t < g;
            if (int'(fg) + int'(fe) + int'(fl) != 1) return;
            if (fe) begin ok = 1; res = g; return; end
            if ((fg && g == 15) || (fl && g == 0)) return;
            if (fg) lo = g + 1; else hi = g - 1;
            if (lo > hi) return;
        end
    endfunction

    task automatic run(input int t, input int m, input bit hold, input bit poke,
                       input int eok, input int eres, input int eit);
        int seq[8];
        int n, res, it, k, w;
        bit ok;
        model(t, m, seq, n, ok, res, it);
        @(negedge clk);
        target = 4'(t); mode = m; start = 1;
        @(negedge clk);
        w = 0;
        while (!busy && w < 4) begin @(negedge clk); w++; end
        if (!hold) start = 0;
        chk("busy", busy, 1);
        k = 0;
        while (busy && k < 8) begin
            chk($sformatf("guess%0d", k), guess, k < n ? seq[k] : -1);
            if (poke) start = k == 1;
            @(negedge clk);
            k++;
        end
        if (poke) start = 0;
        chk("probes", k, n);
        chk("done", done, eok);
        chk("error", error, eok == 0 ? 1 : 0);
        chk("result", result, eres);
        chk("iters", iters, eit);
        mode = 0;
    endtask

    typedef struct {int t; int m; int ok; int res; int it;} vec_t;
    vec_t vecs[6];

    initial begin
        int seq[8];
        int n, res, it, t, m;
        bit ok;
        vecs[0] = '{7, 0, 1, 7, 1};
        vecs[1] = '{15, 0, 1, 15, 5};
        vecs[2] = '{0, 0, 1, 0, 4};
        vecs[3] = '{9, 0, 1, 9, 3};
        vecs[4] = '{5, 1, 0, 0, 1};
        vecs[5] = '{3, 2, 0, 0, 5};
        rst = 1; start = 0; mode = 0; target = 0;
        repeat (2) @(negedge clk);
        chk("rst_guess", guess, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_result", result, 0);
        chk("rst_iters", iters, 0);
        rst = 0;
        foreach (vecs[i]) run(vecs[i].t, vecs[i].m, 0, 0, vecs[i].ok, vecs[i].res, vecs[i].it);
        // result stays at 0 from the last error until a successful search
        run(0, 0, 0, 1, 1, 0, 4);
        repeat (2) begin
            @(negedge clk);
            chk("no_queue", busy, 0);
        end
        for (int i = 0; i < 16; i++) begin
            model(i, 0, seq, n, ok, res, it);
            run(i, 0, 1, 0, 1, i, it);
        end
        start = 0;
        repeat (2) @(negedge clk);
        target = 15; start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        chk("pre_rst_guess", guess, 13);
        #1 rst = 1;
        #1;
        chk("arst_guess", guess, 0);
        chk("arst_busy", busy, 0);
        chk("arst_result", result, 0);
        chk("arst_iters", iters, 0);
        @(negedge clk);
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk("arst_no_done", int'(done || error || busy), 0);
        end
        run(9, 0, 0, 0, 1, 9, 3);
        for (int i = 0; i < 24; i++) begin
            t = int'($urandom_range(0, 15));
            m = int'($urandom_range(0, 2));
            model(t, m, seq, n, ok, res, it);
            run(t, m, 0, 0, int'(ok), res, it);
        end
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
